fp32_div_result_buf: RTL and testbench

Registered result buffer and sticky exception-flag accumulator downstream of the combinational fp32 divider. Each cycle it captures the divider's result word and five IEEE-754 exception flags with a caller tag into a DEPTH-entry FIFO, then presents them through a valid/ready handshake. On commit (dequeue), each entry's flags are ORed into an fflags-style sticky register that software can read, clear or overwrite. A saturating count of committed inexact results is also kept.

---
 rtl/fp32_div_result_buf.sv | 117 +++++++++++
 tb/tb_fp32_div_result_buf.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_div_result_buf.sv
// fp32_div_result_buf
// Registered result buffer downstream of the combinational fp32 divider.
// Divider results (word, five exception flags, caller tag) are queued in a
// DEPTH-entry FIFO and presented through a valid/ready handshake. Each
// committed (dequeued) entry ORs its flags into a sticky fflags register.
// A saturating count of committed inexact results is also kept.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          producer handshake (in_ready from count only)
//   in_y, in_flags, in_tag     result word, {NV,DZ,OF,UF,NX} flags, tag
//   out_valid/out_ready        consumer handshake on the head entry
//   out_y, out_flags, out_tag  head entry fields, zero when empty
//   count                      current occupancy
//   fflags                     sticky flags; fflags_clr / fflags_wr / fflags_wdata
//   nx_cnt, nx_cnt_clr         saturating inexact-commit counter and its clear
module fp32_div_result_buf #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_y,
  input  logic [4:0]                 in_flags,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_y,
  output logic [4:0]                 out_flags,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     count,
  output logic [4:0]                 fflags,
  input  logic                       fflags_clr,
  input  logic                       fflags_wr,
  input  logic [4:0]                 fflags_wdata,
  output logic [15:0]                nx_cnt,
  input  logic                       nx_cnt_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]      mem_y     [DEPTH];
  logic [4:0]       mem_flags [DEPTH];
  logic [TAG_W-1:0] mem_tag   [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          enq;
  logic          deq;
  logic [4:0]    fflags_base;
  logic [4:0]    fflags_next;
  logic [15:0]   nx_base;
  logic [15:0]   nx_next;

  // in_ready is a function of the registered count only, so a full buffer
  // refuses input even when the consumer is draining in the same cycle.
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  assign out_y     = out_valid ? mem_y[rd_ptr]     : '0;
  assign out_flags = out_valid ? mem_flags[rd_ptr] : '0;
  assign out_tag   = out_valid ? mem_tag[rd_ptr]   : '0;

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_y[wr_ptr]     <= in_y;
      mem_flags[wr_ptr] <= in_flags;
      mem_tag[wr_ptr]   <= in_tag;
    end
  end

  // Pointers are exactly AW bits wide so they wrap modulo DEPTH on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Write beats clear; a commit in the same cycle is ORed on top of either,
  // so no committed flag is ever lost.
  always_comb begin
    fflags_base = fflags;
    if (fflags_wr)       fflags_base = fflags_wdata;
    else if (fflags_clr) fflags_base = 5'b0;
    fflags_next = fflags_base | (deq ? out_flags : 5'b0);
  end

  always_comb begin
    nx_base = nx_cnt_clr ? 16'h0 : nx_cnt;
    nx_next = nx_base;
    if (deq && out_flags[0] && (nx_base != 16'hFFFF)) nx_next = nx_base + 16'h1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags <= '0;
      nx_cnt <= '0;
    end else begin
      fflags <= fflags_next;
      nx_cnt <= nx_next;
    end
  end

endmodule

// File: tb/tb_fp32_div_result_buf.sv
// Testbench for fp32_div_result_buf: randomized stimulus checked against a
// queue-based reference model of the buffer, sticky flags and inexact count.
module tb_fp32_div_result_buf;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_y;
  logic [4:0]        in_flags;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_y;
  logic [4:0]        out_flags;
  logic [TAG_W-1:0]  out_tag;
  logic [2:0]        count;
  logic [4:0]        fflags;
  logic              fflags_clr;
  logic              fflags_wr;
  logic [4:0]        fflags_wdata;
  logic [15:0]       nx_cnt;
  logic              nx_cnt_clr;

  always #5 clk = ~clk;

  fp32_div_result_buf #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_flags(out_flags), .out_tag(out_tag),
    .count(count), .fflags(fflags),
    .fflags_clr(fflags_clr), .fflags_wr(fflags_wr), .fflags_wdata(fflags_wdata),
    .nx_cnt(nx_cnt), .nx_cnt_clr(nx_cnt_clr)
  );

  typedef struct {
    logic [31:0]      y;
    logic [4:0]       f;
    logic [TAG_W-1:0] t;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  m_ff;
  logic [15:0] m_nx;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic idle_inputs();
    in_valid = 0; in_y = '0; in_flags = '0; in_tag = '0;
    out_ready = 0; fflags_clr = 0; fflags_wr = 0; fflags_wdata = '0; nx_cnt_clr = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ff = '0;
    m_nx = '0;
  endtask

  // Advance one clock with the currently driven inputs, updating the model.
  // Returns 1 ns after the rising edge.
  task automatic step();
    bit   e, d;
    ent_t h, n;
    logic [4:0] base;
    e = in_valid && (mq.size() < DEPTH);
    d = out_ready && (mq.size() > 0);
    h = '{y: '0, f: '0, t: '0};
    if (d) h = mq[0];
    n = '{y: in_y, f: in_flags, t: in_tag};
    base = fflags_wr ? fflags_wdata : (fflags_clr ? 5'b0 : m_ff);
    m_ff = base | h.f;
    if (nx_cnt_clr) m_nx = 16'h0;
    if (d && h.f[0] && m_nx != 16'hFFFF) m_nx = m_nx + 16'h1;
    @(posedge clk);
    if (d) void'(mq.pop_front());
    if (e) mq.push_back(n);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_tests++; if (out_y !== 32'h0 || out_tag !== '0 || out_flags !== '0) begin n_fail++; $display("FAIL reset_head got y=%h f=%b t=%h want zeros", out_y, out_flags, out_tag); end
    n_tests++; if (fflags !== 5'b0 || nx_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_sticky got ff=%b nx=%0d want 0/0", fflags, nx_cnt); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single();
    idle_inputs();
    in_valid = 1; in_y = 32'h3F800000; in_flags = 5'b0; in_tag = 4'd1;
    step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (out_valid !== 1'b1 || out_y !== 32'h3F800000 || out_tag !== 4'd1) begin n_fail++; $display("FAIL single_hold[%0d] got v=%b y=%h t=%h want 1/3f800000/1", i, out_valid, out_y, out_tag); end
      n_tests++; if (count !== 3'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL single_count[%0d] got cnt=%0d rdy=%b want 1/1", i, count, in_ready); end
      step();
    end
    out_ready = 1;
    step();
    out_ready = 0;
    n_tests++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL single_drain got v=%b cnt=%0d want 0/0", out_valid, count); end
  endtask

  task automatic test_fill();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; in_y = $urandom; in_flags = 5'($urandom); in_tag = TAG_W'(i);
      step();
      n_tests++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, mq.size()); end
    end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready got %b want 0", in_ready); end
    in_y = $urandom; in_tag = 4'hA;
    step();
    n_tests++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ignored got cnt=%0d rdy=%b want 4/0", count, in_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++; if (out_valid !== 1'b1 || out_tag !== TAG_W'(i) || out_y !== mq[0].y || out_flags !== mq[0].f) begin
        n_fail++; $display("FAIL fill_drain[%0d] got v=%b t=%h y=%h f=%b want 1/%h/%h/%b", i, out_valid, out_tag, out_y, out_flags, i, mq[0].y, mq[0].f);
      end
      if (i == 0) begin
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready_with_out_ready got %b want 0", in_ready); end
      end
      out_ready = 1;
      step();
      in_valid = 0;
      n_tests++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL fill_drain_count[%0d] got %0d want %0d", i, count, mq.size()); end
    end
    out_ready = 0;
    n_tests++; if (out_valid !== 1'b0 || out_y !== 32'h0 || out_tag !== '0 || out_flags !== '0) begin n_fail++; $display("FAIL fill_empty got v=%b y=%h t=%h f=%b want zeros", out_valid, out_y, out_tag, out_flags); end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    in_valid = 1; in_y = $urandom; in_flags = 5'($urandom); in_tag = 4'd0;
    step();
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1; in_y = $urandom; in_flags = 5'($urandom); in_tag = TAG_W'(i);
      out_ready = 1;
      n_tests++; if (out_valid !== 1'b1 || out_y !== mq[0].y || out_tag !== mq[0].t || out_flags !== mq[0].f) begin
        n_fail++; $display("FAIL stream_head[%0d] got v=%b y=%h t=%h want 1/%h/%h", i, out_valid, out_y, out_tag, mq[0].y, mq[0].t);
      end
      step();
      n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d] got %0d want 1", i, count); end
    end
    in_valid = 0;
    n_tests++; if (out_tag !== 4'd10) begin n_fail++; $display("FAIL stream_last got %h want a", out_tag); end
    step();
    out_ready = 0;
    n_tests++; if (fflags !== m_ff || nx_cnt !== m_nx) begin n_fail++; $display("FAIL stream_sticky got ff=%b nx=%0d want %b/%0d", fflags, nx_cnt, m_ff, m_nx); end
  endtask

  task automatic test_sticky();
    idle_inputs();
    fflags_clr = 1; nx_cnt_clr = 1;
    step();
    fflags_clr = 0; nx_cnt_clr = 0;
    in_valid = 1; in_y = $urandom; in_flags = 5'b00001; in_tag = 4'd1; step();
    in_y = $urandom; in_flags = 5'b01000; in_tag = 4'd2; step();
    in_valid = 0; out_ready = 1; step(); step(); out_ready = 0;
    n_tests++; if (fflags !== 5'b01001 || nx_cnt !== 16'd1) begin n_fail++; $display("FAIL sticky_accum got ff=%b nx=%0d want 01001/1", fflags, nx_cnt); end
    in_valid = 1; in_flags = 5'b10000; in_tag = 4'd3; step();
    in_valid = 0; out_ready = 1; fflags_clr = 1; step(); out_ready = 0; fflags_clr = 0;
    n_tests++; if (fflags !== 5'b10000) begin n_fail++; $display("FAIL sticky_clr_commit got %b want 10000", fflags); end
    in_valid = 1; in_flags = 5'b00001; in_tag = 4'd4; step();
    in_valid = 0; out_ready = 1; fflags_wr = 1; fflags_wdata = 5'b00100; step();
    out_ready = 0; fflags_wr = 0;
    n_tests++; if (fflags !== 5'b00101 || nx_cnt !== 16'd2) begin n_fail++; $display("FAIL sticky_wr_commit got ff=%b nx=%0d want 00101/2", fflags, nx_cnt); end
    // Random sticky-control mix against the model.
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'($urandom); in_y = $urandom; in_flags = 5'($urandom); in_tag = 4'($urandom);
      out_ready = 1'($urandom); fflags_clr = ($urandom_range(0, 5) == 0);
      fflags_wr = ($urandom_range(0, 5) == 0); fflags_wdata = 5'($urandom);
      nx_cnt_clr = ($urandom_range(0, 7) == 0);
      step();
      n_tests++; if (fflags !== m_ff || nx_cnt !== m_nx || count !== 3'(mq.size())) begin
        n_fail++; $display("FAIL sticky_rand[%0d] got ff=%b nx=%0d cnt=%0d want %b/%0d/%0d", i, fflags, nx_cnt, count, m_ff, m_nx, mq.size());
      end
    end
    idle_inputs();
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) step();
    out_ready = 0;
  endtask

  task automatic test_saturate();
    idle_inputs();
    nx_cnt_clr = 1; step(); nx_cnt_clr = 0;
    in_valid = 1; in_y = $urandom; in_flags = 5'b00001; in_tag = '0;
    step();
    out_ready = 1;
    for (int i = 0; i < 65540; i++) begin
      in_flags = {4'($urandom), 1'b1};
      step();
    end
    in_valid = 0; out_ready = 0;
    n_tests++; if (nx_cnt !== 16'hFFFF || m_nx !== 16'hFFFF) begin n_fail++; $display("FAIL saturate_hold got %h want ffff", nx_cnt); end
    n_tests++; if (count !== 3'd1 || out_flags[0] !== 1'b1) begin n_fail++; $display("FAIL saturate_pending got cnt=%0d nx=%b want 1/1", count, out_flags[0]); end
    nx_cnt_clr = 1; out_ready = 1;
    step();
    nx_cnt_clr = 0; out_ready = 0;
    n_tests++; if (nx_cnt !== 16'd1) begin n_fail++; $display("FAIL saturate_clr_commit got %0d want 1", nx_cnt); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_y = $urandom; in_flags = 5'($urandom) | 5'b00010; in_tag = TAG_W'(i);
      step();
    end
    in_valid = 0;
    n_tests++; if (count !== 3'd3 || fflags === 5'b0) begin n_fail++; $display("FAIL midrst_pre got cnt=%0d ff=%b want 3/nonzero", count, fflags); end
    #2 rst_n = 0;
    model_reset();
    #1;
    n_tests++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_fifo got v=%b cnt=%0d rdy=%b want 0/0/1", out_valid, count, in_ready); end
    n_tests++; if (fflags !== 5'b0 || nx_cnt !== 16'h0 || out_y !== 32'h0) begin n_fail++; $display("FAIL midrst_state got ff=%b nx=%0d y=%h want 0/0/0", fflags, nx_cnt, out_y); end
    @(negedge clk);
    rst_n = 1;
    in_valid = 1; in_y = 32'hC0490FDB; in_flags = 5'b00011; in_tag = 4'd7;
    step();
    in_valid = 0;
    n_tests++; if (out_valid !== 1'b1 || out_y !== 32'hC0490FDB || out_tag !== 4'd7 || count !== 3'd1) begin
      n_fail++; $display("FAIL midrst_first_enq got v=%b y=%h t=%h cnt=%0d want 1/c0490fdb/7/1", out_valid, out_y, out_tag, count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_sticky();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
